// File: rtl/execute_ldst_sequencer_pkg.sv
// Shared types for the execute-stage load/store sequencer: FSM state codes,
// access-order codes, the latched request record and the load extension helper.
package execute_ldst_sequencer_pkg;

   typedef enum logic [2:0] {
      LDSTSEQ_IDLE  = 3'd0,
      LDSTSEQ_REQ   = 3'd1,
      LDSTSEQ_WAIT  = 3'd2,
      LDSTSEQ_OUT   = 3'd3,
      LDSTSEQ_DRAIN = 3'd4
   } ldstseq_state_e;

   localparam logic [1:0] LDST_ORDER_BYTE = 2'd0;
   localparam logic [1:0] LDST_ORDER_HALF = 2'd1;
   localparam logic [1:0] LDST_ORDER_WORD = 2'd2;

   typedef struct packed {
      logic        rw;
      logic [31:0] pdt;
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  order;
      logic [3:0]  mask;
      logic [1:0]  shift;
      logic        sgn;
      logic [4:0]  dest;
   } ldst_req_t;

   // Select the low byte/half/word of an already shifted word and extend it.
   function automatic logic [31:0] ldst_extend(input logic [31:0] w,
                                               input logic [1:0]  order,
                                               input logic        sgn);
      logic [31:0] r;
      case (order)
         LDST_ORDER_BYTE: r = {{24{sgn & w[7]}}, w[7:0]};
         LDST_ORDER_HALF: r = {{16{sgn & w[15]}}, w[15:0]};
         LDST_ORDER_WORD: r = w;
         default:         r = 32'h0000_0000;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/execute_ldst_sequencer_load_align.sv
// Combinational load-data aligner: shifts the returned word down by whole
// bytes, then selects and extends the byte/half/word lane.
module execute_ldst_load_align
   import execute_ldst_sequencer_pkg::*;
(
   input  logic [31:0] iDATA,
   input  logic [1:0]  iSHIFT,
   input  logic [1:0]  iORDER,
   input  logic        iSIGNED,
   output logic [31:0] oDATA
);

   logic [31:0] shifted_s;

   // Byte shift followed by lane selection and extension.
   always_comb begin
      shifted_s = iDATA >> {iSHIFT, 3'b000};
      oDATA     = ldst_extend(shifted_s, iORDER, iSIGNED);
   end

endmodule

// File: rtl/execute_ldst_sequencer.sv
// Holds one load/store from execute until memory accepts it, waits for load
// data, aligns it and hands the result to writeback; drains cleanly on flush.
module execute_ldst_sequencer
   import execute_ldst_sequencer_pkg::*;
(
   input  logic        iCLOCK,
   input  logic        iRESET_SYNC,
   input  logic        iFREE_REFRESH,
   input  logic        iPREV_VALID,
   output logic        oPREV_LOCK,
   input  logic        iPREV_RW,
   input  logic [31:0] iPREV_PDT,
   input  logic [31:0] iPREV_ADDR,
   input  logic [31:0] iPREV_DATA,
   input  logic [1:0]  iPREV_ORDER,
   input  logic [3:0]  iPREV_MASK,
   input  logic [1:0]  iPREV_SHIFT,
   input  logic        iPREV_SIGNED,
   input  logic [4:0]  iPREV_DESTINATION,
   output logic        oDATAIO_REQ,
   input  logic        iDATAIO_BUSY,
   output logic        oDATAIO_RW,
   output logic [1:0]  oDATAIO_ORDER,
   output logic [3:0]  oDATAIO_MASK,
   output logic [31:0] oDATAIO_PDT,
   output logic [31:0] oDATAIO_ADDR,
   output logic [31:0] oDATAIO_DATA,
   input  logic        iDATAIO_REQ,
   input  logic [31:0] iDATAIO_DATA,
   output logic        oNEXT_VALID,
   input  logic        iNEXT_BUSY,
   output logic        oNEXT_WRITEBACK,
   output logic [31:0] oNEXT_DATA,
   output logic [4:0]  oNEXT_DESTINATION
);

   ldstseq_state_e state_q, state_d;
   ldst_req_t      req_q, req_d;
   logic [31:0]    rdata_q, rdata_d;
   logic [31:0]    align_s;
   logic           accept_s;

   execute_ldst_load_align u_align (
      .iDATA   (iDATAIO_DATA),
      .iSHIFT  (req_q.shift),
      .iORDER  (req_q.order),
      .iSIGNED (req_q.sgn),
      .oDATA   (align_s)
   );

   // State, request latch and result register.
   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         state_q <= LDSTSEQ_IDLE;
         req_q   <= '0;
         rdata_q <= 32'h0000_0000;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         rdata_q <= rdata_d;
      end
   end

   // Next state; flush overrides every transition, but an issued request
   // still has to be accounted for (store stands, load drains its data).
   always_comb begin
      state_d = state_q;
      case (state_q)
         LDSTSEQ_IDLE: begin
            if (iPREV_VALID && !iFREE_REFRESH) state_d = LDSTSEQ_REQ;
            else                               state_d = LDSTSEQ_IDLE;
         end
         LDSTSEQ_REQ: begin
            if (!iDATAIO_BUSY) begin
               if (req_q.rw) state_d = iFREE_REFRESH ? LDSTSEQ_IDLE  : LDSTSEQ_OUT;
               else          state_d = iFREE_REFRESH ? LDSTSEQ_DRAIN : LDSTSEQ_WAIT;
            end else if (iFREE_REFRESH) begin
               state_d = LDSTSEQ_IDLE;
            end else begin
               state_d = LDSTSEQ_REQ;
            end
         end
         LDSTSEQ_WAIT: begin
            if (iDATAIO_REQ)        state_d = iFREE_REFRESH ? LDSTSEQ_IDLE : LDSTSEQ_OUT;
            else if (iFREE_REFRESH) state_d = LDSTSEQ_DRAIN;
            else                    state_d = LDSTSEQ_WAIT;
         end
         LDSTSEQ_OUT: begin
            if (iFREE_REFRESH || !iNEXT_BUSY) state_d = LDSTSEQ_IDLE;
            else                              state_d = LDSTSEQ_OUT;
         end
         LDSTSEQ_DRAIN: begin
            if (iDATAIO_REQ) state_d = LDSTSEQ_IDLE;
            else             state_d = LDSTSEQ_DRAIN;
         end
         default: state_d = LDSTSEQ_IDLE;
      endcase
   end

   // Request capture on accept; aligned load data captured on return.
   always_comb begin
      accept_s = (state_q == LDSTSEQ_IDLE) && iPREV_VALID && !iFREE_REFRESH;
      req_d    = req_q;
      rdata_d  = rdata_q;
      if (accept_s) begin
         req_d.rw    = iPREV_RW;
         req_d.pdt   = iPREV_PDT;
         req_d.addr  = iPREV_ADDR;
         req_d.data  = iPREV_DATA;
         req_d.order = iPREV_ORDER;
         req_d.mask  = iPREV_MASK;
         req_d.shift = iPREV_SHIFT;
         req_d.sgn   = iPREV_SIGNED;
         req_d.dest  = iPREV_DESTINATION;
         rdata_d     = 32'h0000_0000;
      end else if ((state_q == LDSTSEQ_WAIT) && iDATAIO_REQ && !iFREE_REFRESH) begin
         rdata_d = align_s;
      end else begin
         rdata_d = rdata_q;
      end
   end

   // Outputs decoded purely from registered state and latched fields.
   always_comb begin
      oPREV_LOCK        = (state_q != LDSTSEQ_IDLE);
      oDATAIO_REQ       = (state_q == LDSTSEQ_REQ);
      oDATAIO_RW        = req_q.rw;
      oDATAIO_ORDER     = req_q.order;
      oDATAIO_MASK      = req_q.mask;
      oDATAIO_PDT       = req_q.pdt;
      oDATAIO_ADDR      = req_q.addr;
      oDATAIO_DATA      = req_q.data;
      oNEXT_VALID       = (state_q == LDSTSEQ_OUT);
      oNEXT_WRITEBACK   = (state_q == LDSTSEQ_OUT) && !req_q.rw;
      oNEXT_DATA        = rdata_q;
      oNEXT_DESTINATION = req_q.dest;
   end

endmodule

// File: tb/tb_execute_ldst_sequencer.sv
// Self-checking bench for execute_ldst_sequencer: table-driven load alignment
// vectors with a result scoreboard, plus hand-written multi-cycle sequences.
module tb_execute_ldst_sequencer;

   logic        clk = 1'b0;
   logic        rst, flush, prev_valid, prev_rw, prev_signed;
   logic [31:0] prev_pdt, prev_addr, prev_data;
   logic [1:0]  prev_order, prev_shift;
   logic [3:0]  prev_mask;
   logic [4:0]  prev_dest;
   logic        dio_busy, dio_rvalid, next_busy;
   logic [31:0] dio_rdata;
   logic        lock, dio_req, dio_rw, next_valid, next_wb;
   logic [1:0]  dio_order;
   logic [3:0]  dio_mask;
   logic [31:0] dio_pdt, dio_addr, dio_data, next_data;
   logic [4:0]  next_dest;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [1:0]  shift;
      logic [1:0]  order;
      logic        sgn;
      logic [31:0] word;
      logic [4:0]  dest;
      logic [31:0] exp;
   } vec_t;

   typedef struct packed {
      logic        wb;
      logic [31:0] data;
      logic [4:0]  dest;
   } res_t;

   vec_t vecs[8];
   res_t sb_q[$];

   always #5 clk = ~clk;

   execute_ldst_sequencer dut (
      .iCLOCK(clk), .iRESET_SYNC(rst), .iFREE_REFRESH(flush),
      .iPREV_VALID(prev_valid), .oPREV_LOCK(lock), .iPREV_RW(prev_rw),
      .iPREV_PDT(prev_pdt), .iPREV_ADDR(prev_addr), .iPREV_DATA(prev_data),
      .iPREV_ORDER(prev_order), .iPREV_MASK(prev_mask), .iPREV_SHIFT(prev_shift),
      .iPREV_SIGNED(prev_signed), .iPREV_DESTINATION(prev_dest),
      .oDATAIO_REQ(dio_req), .iDATAIO_BUSY(dio_busy), .oDATAIO_RW(dio_rw),
      .oDATAIO_ORDER(dio_order), .oDATAIO_MASK(dio_mask), .oDATAIO_PDT(dio_pdt),
      .oDATAIO_ADDR(dio_addr), .oDATAIO_DATA(dio_data),
      .iDATAIO_REQ(dio_rvalid), .iDATAIO_DATA(dio_rdata),
      .oNEXT_VALID(next_valid), .iNEXT_BUSY(next_busy),
      .oNEXT_WRITEBACK(next_wb), .oNEXT_DATA(next_data),
      .oNEXT_DESTINATION(next_dest)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   // Offer one operation for a single cycle; afterwards the bench is in the REQ cycle.
   task automatic issue(input logic rw, input logic [31:0] addr, input logic [31:0] data,
                        input logic [1:0] order, input logic [3:0] mask,
                        input logic [1:0] shift, input logic sgn, input logic [4:0] dest);
      prev_valid  = 1'b1;
      prev_rw     = rw;
      prev_pdt    = addr ^ 32'hA5A5_0000;
      prev_addr   = addr;
      prev_data   = data;
      prev_order  = order;
      prev_mask   = mask;
      prev_shift  = shift;
      prev_signed = sgn;
      prev_dest   = dest;
      cyc();
      prev_valid  = 1'b0;
      prev_addr   = $urandom;
      prev_data   = $urandom;
      prev_pdt    = $urandom;
      prev_dest   = 5'($urandom);
   endtask

   // Wait (bounded) for a valid result and compare it against the scoreboard head.
   task automatic expect_result(input string name);
      int   t;
      res_t e;
      t = 0;
      while (!next_valid && t < 20) begin
         cyc();
         t++;
      end
      if (!next_valid) begin
         chk({name, "_timeout"}, 32'(next_valid), 32'd1);
      end else if (sb_q.size() == 0) begin
         chk({name, "_unexpected"}, 32'(next_valid), 32'd0);
      end else begin
         e = sb_q.pop_front();
         chk({name, "_data"}, next_data, e.data);
         chk({name, "_wb"},   32'(next_wb), 32'(e.wb));
         chk({name, "_dest"}, 32'(next_dest), 32'(e.dest));
      end
   endtask

   initial begin
      vecs[0] = '{2'd3, 2'd0, 1'b1, 32'h8012_3456, 5'd5,  32'hFFFF_FF80};
      vecs[1] = '{2'd3, 2'd0, 1'b0, 32'h8012_3456, 5'd17, 32'h0000_0080};
      vecs[2] = '{2'd0, 2'd1, 1'b1, 32'h1234_8001, 5'd3,  32'hFFFF_8001};
      vecs[3] = '{2'd2, 2'd1, 1'b0, 32'hABCD_0000, 5'd9,  32'h0000_ABCD};
      vecs[4] = '{2'd0, 2'd2, 1'b1, 32'hDEAD_BEEF, 5'd31, 32'hDEAD_BEEF};
      vecs[5] = '{2'd1, 2'd3, 1'b1, 32'hFFFF_FFFF, 5'd1,  32'h0000_0000};
      vecs[6] = '{2'd1, 2'd0, 1'b1, 32'h0000_7F00, 5'd12, 32'h0000_007F};
      vecs[7] = '{2'd2, 2'd1, 1'b1, 32'h8000_0000, 5'd22, 32'hFFFF_8000};

      rst = 1'b1; flush = 1'b0; prev_valid = 1'b0; prev_rw = 1'b0; prev_signed = 1'b0;
      prev_pdt = 32'h0; prev_addr = 32'h0; prev_data = 32'h0; prev_order = 2'd0;
      prev_shift = 2'd0; prev_mask = 4'h0; prev_dest = 5'd0;
      dio_busy = 1'b0; dio_rvalid = 1'b0; dio_rdata = 32'h0; next_busy = 1'b0;
      cyc(); cyc();
      rst = 1'b0;
      chk("rst_lock",  32'(lock), 32'd0);
      chk("rst_req",   32'(dio_req), 32'd0);
      chk("rst_valid", 32'(next_valid), 32'd0);
      chk("rst_wb",    32'(next_wb), 32'd0);
      chk("rst_addr",  dio_addr, 32'h0);

      // Table-driven loads through the aligner.
      for (int i = 0; i < 8; i++) begin
         issue(1'b0, 32'h2000 + 32'(i * 4), 32'h0, vecs[i].order, 4'hF,
               vecs[i].shift, vecs[i].sgn, vecs[i].dest);
         chk($sformatf("ld%0d_req", i),  32'(dio_req), 32'd1);
         chk($sformatf("ld%0d_addr", i), dio_addr, 32'h2000 + 32'(i * 4));
         chk($sformatf("ld%0d_rw", i),   32'(dio_rw), 32'd0);
         cyc();
         chk($sformatf("ld%0d_wait_req", i), 32'(dio_req), 32'd0);
         dio_rvalid = 1'b1;
         dio_rdata  = vecs[i].word;
         sb_q.push_back('{1'b1, vecs[i].exp, vecs[i].dest});
         cyc();
         dio_rvalid = 1'b0;
         dio_rdata  = $urandom;
         expect_result($sformatf("ld%0d", i));
         cyc();
         chk($sformatf("ld%0d_unlock", i), 32'(lock), 32'd0);
      end

      // Store, no backpressure: one REQ cycle, result two cycles after accept.
      issue(1'b1, 32'h0000_1002, 32'hBEEF_0000, 2'd1, 4'b1100, 2'd0, 1'b0, 5'd7);
      chk("st_req",   32'(dio_req), 32'd1);
      chk("st_rw",    32'(dio_rw), 32'd1);
      chk("st_addr",  dio_addr, 32'h0000_1002);
      chk("st_order", 32'(dio_order), 32'd1);
      chk("st_mask",  32'(dio_mask), 32'hC);
      chk("st_data",  dio_data, 32'hBEEF_0000);
      chk("st_pdt",   dio_pdt, 32'h0000_1002 ^ 32'hA5A5_0000);
      sb_q.push_back('{1'b0, 32'h0, 5'd7});
      cyc();
      chk("st_req_once", 32'(dio_req), 32'd0);
      chk("st_valid_n2", 32'(next_valid), 32'd1);
      expect_result("st");
      cyc();
      chk("st_unlock", 32'(lock), 32'd0);

      // Memory busy for 4 cycles, then writeback stalled.
      dio_busy = 1'b1;
      issue(1'b0, 32'h0000_3004, 32'h0, 2'd0, 4'h1, 2'd0, 1'b0, 5'd14);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp_req%0d", i),  32'(dio_req), 32'd1);
         chk($sformatf("bp_addr%0d", i), dio_addr, 32'h0000_3004);
         chk($sformatf("bp_mask%0d", i), 32'(dio_mask), 32'h1);
         if (i == 4) dio_busy = 1'b0;
         cyc();
      end
      chk("bp_wait", 32'(dio_req), 32'd0);
      next_busy  = 1'b1;
      dio_rvalid = 1'b1;
      dio_rdata  = 32'h0000_00A5;
      sb_q.push_back('{1'b1, 32'h0000_00A5, 5'd14});
      cyc();
      dio_rvalid = 1'b0;
      dio_rdata  = 32'h0;
      expect_result("bp");
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("bp_hold_valid%0d", i), 32'(next_valid), 32'd1);
         chk($sformatf("bp_hold_data%0d", i),  next_data, 32'h0000_00A5);
         if (i == 3) next_busy = 1'b0;
         cyc();
      end
      chk("bp_done", 32'(next_valid), 32'd0);

      // Flush in WAIT: drain the late return, then accept the next operation.
      issue(1'b0, 32'h0000_4000, 32'h0, 2'd2, 4'hF, 2'd0, 1'b0, 5'd4);
      cyc();
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      chk("fw_lock", 32'(lock), 32'd1);
      chk("fw_valid", 32'(next_valid), 32'd0);
      cyc();
      chk("fw_lock2", 32'(lock), 32'd1);
      dio_rvalid = 1'b1;
      dio_rdata  = 32'h1111_2222;
      cyc();
      dio_rvalid = 1'b0;
      chk("fw_unlock", 32'(lock), 32'd0);
      chk("fw_novalid", 32'(next_valid), 32'd0);
      issue(1'b1, 32'h0000_4100, 32'h0000_0055, 2'd0, 4'h1, 2'd0, 1'b0, 5'd0);
      chk("fw_next_req", 32'(dio_req), 32'd1);
      sb_q.push_back('{1'b0, 32'h0, 5'd0});
      cyc();
      expect_result("fw_next");
      cyc();

      // Flush while REQ is stalled: request withdrawn.
      dio_busy = 1'b1;
      issue(1'b0, 32'h0000_5000, 32'h0, 2'd2, 4'hF, 2'd0, 1'b0, 5'd6);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      dio_busy = 1'b0;
      chk("fr_req", 32'(dio_req), 32'd0);
      chk("fr_lock", 32'(lock), 32'd0);

      // Flush as a store issues: write reaches memory, nothing to writeback.
      issue(1'b1, 32'h0000_6000, 32'hCAFE_F00D, 2'd2, 4'hF, 2'd0, 1'b0, 5'd8);
      chk("fs_req", 32'(dio_req), 32'd1);
      chk("fs_data", dio_data, 32'hCAFE_F00D);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      chk("fs_lock", 32'(lock), 32'd0);
      chk("fs_valid", 32'(next_valid), 32'd0);
      cyc();
      chk("fs_valid2", 32'(next_valid), 32'd0);

      // Flush in IDLE blocks acceptance.
      flush = 1'b1;
      prev_valid = 1'b1;
      cyc();
      flush = 1'b0;
      prev_valid = 1'b0;
      chk("fi_lock", 32'(lock), 32'd0);

      // Flush in OUT drops the result.
      next_busy = 1'b1;
      issue(1'b0, 32'h0000_7000, 32'h0, 2'd2, 4'hF, 2'd0, 1'b0, 5'd9);
      cyc();
      dio_rvalid = 1'b1;
      dio_rdata  = 32'h5A5A_5A5A;
      cyc();
      dio_rvalid = 1'b0;
      chk("fo_valid", 32'(next_valid), 32'd1);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      next_busy = 1'b0;
      chk("fo_drop", 32'(next_valid), 32'd0);
      chk("fo_lock", 32'(lock), 32'd0);

      // Reset while a load waits; a late return is ignored.
      issue(1'b0, 32'h0000_8000, 32'h1234_5678, 2'd2, 4'hF, 2'd0, 1'b0, 5'd10);
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("rw_lock",  32'(lock), 32'd0);
      chk("rw_req",   32'(dio_req), 32'd0);
      chk("rw_addr",  dio_addr, 32'h0);
      chk("rw_data",  dio_data, 32'h0);
      chk("rw_dest",  32'(next_dest), 32'd0);
      chk("rw_valid", 32'(next_valid), 32'd0);
      dio_rvalid = 1'b1;
      dio_rdata  = 32'hFFFF_FFFF;
      cyc();
      dio_rvalid = 1'b0;
      chk("rw_late_valid", 32'(next_valid), 32'd0);
      chk("rw_late_data",  next_data, 32'h0);
      chk("rw_late_lock",  32'(lock), 32'd0);

      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/execute_ldst_sequencer.md
# execute_ldst_sequencer

Sequences one load/store operation from the execute stage to the data memory port. It sits between the address/byte-lane calculation stage and the data I/O interface. It holds the request until memory accepts it, waits for load return data, then aligns and extends that data. It hands the result to writeback through a valid/busy handshake and drains safely on pipeline flush.

## Interface
- No parameters; all widths fixed by the ISA: data/address/PDT 32, order 2, mask 4, shift 2, destination 5.
- iCLOCK  in  1  core clock
- iRESET_SYNC  in  1  synchronous reset, active-high
- iFREE_REFRESH  in  1  pipeline flush
- iPREV_VALID  in  1  operation offered
- oPREV_LOCK  out  1  sequencer busy; upstream holds its operation
- iPREV_RW  in  1  0 load, 1 store
- iPREV_PDT / iPREV_ADDR / iPREV_DATA  in  32 each  page-table base, address, lane-positioned store data
- iPREV_ORDER  in  2  0 byte, 1 half, 2 word
- iPREV_MASK  in  4  byte-lane mask
- iPREV_SHIFT  in  2  load byte shift
- iPREV_SIGNED  in  1  sign-extend load
- iPREV_DESTINATION  in  5  load destination register
- oDATAIO_REQ  out  1  memory request
- iDATAIO_BUSY  in  1  memory cannot accept
- oDATAIO_RW / oDATAIO_ORDER / oDATAIO_MASK / oDATAIO_PDT / oDATAIO_ADDR / oDATAIO_DATA  out  1/2/4/32/32/32  latched request fields
- iDATAIO_REQ  in  1  load data valid (one cycle)
- iDATAIO_DATA  in  32  raw load word
- oNEXT_VALID  out  1  result valid
- iNEXT_BUSY  in  1  writeback stall
- oNEXT_WRITEBACK  out  1  1 for load, 0 for store
- oNEXT_DATA  out  32  aligned load data (0 for store)
- oNEXT_DESTINATION  out  5  latched destination

## Operation
- States: IDLE, REQ, WAIT, OUT, DRAIN. oPREV_LOCK = (state != IDLE).
- IDLE: if iPREV_VALID & !iFREE_REFRESH → latch all iPREV_* fields → REQ.
- REQ: oDATAIO_REQ=1.
  - If !iDATAIO_BUSY: a store → OUT; a load → WAIT.
  - If busy: hold REQ, with all request fields stable.
- WAIT: when iDATAIO_REQ: capture aligned data → OUT.
- OUT: oNEXT_VALID=1, outputs stable. When !iNEXT_BUSY → IDLE.
- DRAIN: waits for iDATAIO_REQ, discards the data → IDLE.
- Alignment:
  - w = iDATAIO_DATA >> (8·shift).
  - order 0: w[7:0], extended from bit 7 if signed, else zero.
  - order 1: w[15:0], extended from bit 15 if signed, else zero.
  - order 2: w unchanged.
  - order 3: result 0.
- Flush (iFREE_REFRESH=1), which has priority over every other transition:
  - IDLE: no accept.
  - REQ with busy=1: → IDLE, request withdrawn.
  - REQ with busy=0: the request is issued. A store → IDLE (the memory write stands). A load → DRAIN.
  - WAIT: → DRAIN, or → IDLE if iDATAIO_REQ arrives in the same cycle.
  - OUT: → IDLE, result dropped.
  - DRAIN: stays in DRAIN.
- iDATAIO_REQ outside WAIT/DRAIN is ignored.

## Timing
- Reset: state IDLE; every output 0, including latched fields, oPREV_LOCK, oDATAIO_REQ and oNEXT_VALID. Reset overrides flush and handshakes.
- Accept at edge N → oDATAIO_REQ high in cycle N+1.
- Store with no busy: oNEXT_VALID in N+2. Minimum issue interval is 3 cycles.
- Load: oNEXT_VALID the cycle after the iDATAIO_REQ edge. No combinational path from iDATAIO_DATA to oNEXT_DATA.
- oPREV_LOCK is registered-state based: it rises the cycle after acceptance and falls the cycle after OUT completes.

## Structure
- core.h gets state encodings `LDSTSEQ_IDLE…`LDSTSEQ_DRAIN and the order codes `LDST_ORDER_BYTE/HALF/WORD (0/1/2).
- One combinational sub-module, execute_ldst_load_align, implements shift, order and signed → 32-bit result.
- The FSM and latches stay in the top module.

## Test plan
- Store: addr 0x1002, order 1, mask 1100, data 0xBEEF0000, busy=0 → REQ for exactly 1 cycle with those fields; oNEXT_VALID at N+2, WRITEBACK=0.
- Signed byte load: shift 3, returned word 0x80123456 → oNEXT_DATA 0xFFFFFF80, dest latched. The same with signed=0 → 0x00000080.
- Busy backpressure: iDATAIO_BUSY high for 4 cycles → oDATAIO_REQ and all fields stable for 5 cycles, then WAIT. iNEXT_BUSY held 3 cycles → OUT held, data stable.
- Flush in WAIT, data returns 2 cycles later → DRAIN, no oNEXT_VALID. oPREV_LOCK stays high until the return, then the next op is accepted.
- Flush in REQ with busy=1 → no request issued, IDLE next cycle. Flush with busy=0 on a store → memory sees the write, no writeback.
- Reset asserted in WAIT with a pending load → all outputs 0 next cycle; a late iDATAIO_REQ is ignored.
